reg_scoreboard: RTL and testbench

- Producer-side companion to the pipeline's operand forwarding logic.
- Tracks in-flight destination registers from ID issue until writeback.
- Tells decode whether each source operand can be forwarded, or whether the pipeline must stall (load-use or a not-yet-forwardable producer).
- Sits beside the ID stage; driven by the issue slot and the WB stage.

---
 rtl/reg_scoreboard.sv | 124 ++++++++++++
 tb/tb_reg_scoreboard.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - in-flight destination register scoreboard driving stall and forward hints
// Optional stall-cycle counter output enabled by defining REG_SCOREBOARD_STATS_EN.
module reg_scoreboard #(
  parameter int NREG         = 32,
  parameter int AGE_W        = 2,
  parameter int ALU_FWD_AGE  = 1,
  parameter int LOAD_FWD_AGE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_regwrite,
  input  logic        issue_is_load,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rt1,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        stall,
  output logic        pending_rs,
  output logic        pending_rt,
`ifdef REG_SCOREBOARD_STATS_EN
  output logic [31:0] stall_cycles,
`endif
  output logic [5:0]  pending_count
);

  logic [NREG-1:0]  pend_q, pend_d;
  logic [NREG-1:0]  load_q, load_d;
  logic [AGE_W-1:0] age_q [NREG];
  logic [AGE_W-1:0] age_d [NREG];
  logic [5:0]       count_q, count_d;
  logic [NREG-1:0]  fwd_ok;
  logic             hazard_rs, hazard_rt, eff_issue;

  always_comb begin
    fwd_ok = '0;
    for (int r = 0; r < NREG; r++) begin
      fwd_ok[r] = load_q[r] ? (int'(age_q[r]) >= LOAD_FWD_AGE)
                            : (int'(age_q[r]) >= ALU_FWD_AGE);
    end
  end

  always_comb begin
    hazard_rs  = (rs1 != 5'd0) && pend_q[rs1] && !fwd_ok[rs1];
    hazard_rt  = (rt1 != 5'd0) && pend_q[rt1] && !fwd_ok[rt1];
    stall      = hazard_rs | hazard_rt;
    pending_rs = (rs1 != 5'd0) && pend_q[rs1] && fwd_ok[rs1];
    pending_rt = (rt1 != 5'd0) && pend_q[rt1] && fwd_ok[rt1];
    eff_issue  = issue_valid && issue_regwrite && !stall && !flush && (issue_rd != 5'd0);
  end

  // Later updates override earlier ones: age, then WB clear, then issue, then flush.
  always_comb begin
    pend_d = pend_q;
    load_d = load_q;
    age_d  = age_q;
    for (int r = 0; r < NREG; r++) begin
      if (pend_q[r] && (age_q[r] != {AGE_W{1'b1}})) begin
        age_d[r] = age_q[r] + 1'b1;
      end
    end
    if (wb_valid && (wb_rd != 5'd0)) begin
      pend_d[wb_rd] = 1'b0;
    end
    if (eff_issue) begin
      pend_d[issue_rd] = 1'b1;
      load_d[issue_rd] = issue_is_load;
      age_d[issue_rd]  = '0;
    end
    if (flush) begin
      pend_d = '0;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int r = 0; r < NREG; r++) begin
      count_d = count_d + 6'(pend_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        age_q[r] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      load_q  <= load_d;
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

  assign pending_count = count_q;

`ifdef REG_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized and directed checks of reg_scoreboard against a behavioural model
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_regwrite, issue_is_load;
  logic [4:0]  issue_rd, rs1, rt1, wb_rd;
  logic        wb_valid, flush;
  logic        stall, pending_rs, pending_rt;
  logic [5:0]  pending_count;
`ifdef REG_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .rs1(rs1), .rt1(rt1), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .pending_rs(pending_rs), .pending_rt(pending_rt),
`ifdef REG_SCOREBOARD_STATS_EN
    .stall_cycles(stall_cycles),
`endif
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          cmp_en = 1'b0;
  bit          m_pend [32];
  bit          m_load [32];
  int          m_age  [32];
  int unsigned m_stalls;

  function automatic bit m_fwd(int r);
    return m_load[r] ? (m_age[r] >= 2) : (m_age[r] >= 1);
  endfunction
  function automatic bit m_haz(int s);
    return (s != 0) && m_pend[s] && !m_fwd(s);
  endfunction
  function automatic bit m_fpend(int s);
    return (s != 0) && m_pend[s] && m_fwd(s);
  endfunction
  function automatic int m_cnt();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_pend[r]);
    return c;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("stall", {31'd0, stall}, {31'd0, m_haz(int'(rs1)) | m_haz(int'(rt1))});
      check("pending_rs", {31'd0, pending_rs}, {31'd0, m_fpend(int'(rs1))});
      check("pending_rt", {31'd0, pending_rt}, {31'd0, m_fpend(int'(rt1))});
      check("pending_count", {26'd0, pending_count}, m_cnt());
`ifdef REG_SCOREBOARD_STATS_EN
      check("stall_cycles", stall_cycles, m_stalls);
`endif
    end
  end

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_pend[r] = 0; m_load[r] = 0; m_age[r] = 0;
    end
    m_stalls = 0;
  endtask

  task automatic model_update();
    bit st;
    bit eff;
    st  = m_haz(int'(rs1)) | m_haz(int'(rt1));
    eff = issue_valid && issue_regwrite && !st && !flush && (issue_rd != 0);
    if (st) m_stalls++;
    for (int r = 0; r < 32; r++) if (m_pend[r] && m_age[r] < 3) m_age[r]++;
    if (wb_valid && wb_rd != 0) m_pend[wb_rd] = 0;
    if (eff) begin
      m_pend[issue_rd] = 1; m_age[issue_rd] = 0; m_load[issue_rd] = issue_is_load;
    end
    if (flush) for (int r = 0; r < 32; r++) m_pend[r] = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_regwrite = 0; issue_is_load = 0; issue_rd = 0;
    rs1 = 0; rt1 = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic issue(logic [4:0] rd, logic ld);
    issue_valid = 1; issue_regwrite = 1; issue_is_load = ld; issue_rd = rd;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    cmp_en = 1;
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_count", {26'd0, pending_count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 0;

    // ALU dependency: age 0 stalls, age 1 forwards
    issue(5'd5, 0); step();
    idle(); rs1 = 5'd5; #1;
    check("alu_age0_stall", {31'd0, stall}, 32'd1);
    step();
    check("alu_age1_stall", {31'd0, stall}, 32'd0);
    check("alu_age1_pend_rs", {31'd0, pending_rs}, 32'd1);

    // Load-use: two stall cycles, dependent issue held off
    do_reset();
    idle(); issue(5'd7, 1); step();
    issue(5'd8, 0); rt1 = 5'd7; #1;
    check("ld_use_stall1", {31'd0, stall}, 32'd1);
    step();
    check("ld_use_stall2", {31'd0, stall}, 32'd1);
    check("ld_use_held", {26'd0, pending_count}, 32'd1);
    step();
    check("ld_use_clear", {31'd0, stall}, 32'd0);
    check("ld_use_pend_rt", {31'd0, pending_rt}, 32'd1);
    step();
    check("ld_use_issued", {26'd0, pending_count}, 32'd2);
`ifdef REG_SCOREBOARD_STATS_EN
    check("stats_two", stall_cycles, 32'd2);
    idle(); flush = 1; step(); idle();
    check("stats_after_flush", stall_cycles, 32'd2);
`endif

    // WB/issue collision on rd=9 at age 3
    do_reset();
    idle(); issue(5'd9, 0); step();
    issue(5'd4, 0); step();
    idle(); step(); step();
    wb_valid = 1; wb_rd = 5'd9; issue(5'd9, 1); step();
    idle(); rs1 = 5'd9; #1;
    check("coll_count", {26'd0, pending_count}, 32'd2);
    check("coll_age0_load", {31'd0, stall}, 32'd1);
    step(); step();
    check("coll_age2_fwd", {31'd0, pending_rs}, 32'd1);

    // Register zero and flush
    do_reset();
    idle(); issue(5'd0, 0); step();
    check("rd0_count", {26'd0, pending_count}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i), 0); step();
    end
    check("four_pending", {26'd0, pending_count}, 32'd4);
    flush = 1; issue(5'd3, 0); step();
    idle(); rs1 = 5'd3; #1;
    check("flush_count", {26'd0, pending_count}, 32'd0);
    check("flush_no_stall", {31'd0, stall}, 32'd0);

    // Asynchronous reset with three producers in flight
    do_reset();
    idle(); issue(5'd1, 0); step(); issue(5'd2, 0); step(); issue(5'd3, 1); step();
    idle(); rs1 = 5'd3; rt1 = 5'd1; #1;
    check("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1; #1;
    model_reset();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_pend_rs", {31'd0, pending_rs}, 32'd0);
    check("rst_pend_rt", {31'd0, pending_rt}, 32'd0);
    @(posedge clk); #1; rst = 0;
    check("rst_count", {26'd0, pending_count}, 32'd0);

    // Randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      issue_valid    = ($urandom_range(0, 3) != 0);
      issue_regwrite = ($urandom_range(0, 4) != 0);
      issue_is_load  = $urandom_range(0, 1);
      issue_rd       = 5'($urandom_range(0, 9));
      rs1            = 5'($urandom_range(0, 9));
      rt1            = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      wb_valid       = $urandom_range(0, 1);
      wb_rd          = 5'($urandom_range(0, 9));
      flush          = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 500) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
